// File: rtl/shift_pkg.sv
// Shared definitions for the serial transmit path: FSM state encoding,
// gap counter width and the bit counter width helper.
package shift_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   // Gap counter covers a programmable gap of 0..15 idle cycles.
   localparam int GAP_CNT_W = 4;

   // Bit counter width for a word of the given width; never narrower than 1.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter feeding a downstream SIPO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a word; din_ready high
// ST_SHIFT | presenting one data bit per cycle; ready only on last bit
//          | when no gap is configured (back-to-back words)
// ST_GAP   | GAP idle cycles after a word, nothing accepted
module piso_tx
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned LSB_FIRST = 1,
   parameter int unsigned GAP       = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_en,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0]        LAST_BIT = CW'(WIDTH - 1);
   // Only meaningful when GAP > 0; ST_GAP is never entered otherwise.
   localparam logic [GAP_CNT_W-1:0] GAP_LAST = (GAP == 0) ? '0 : GAP_CNT_W'(GAP - 1);

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       shreg_q, shreg_d;
   logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;

   logic                   last_bit;
   logic                   xfer;
   logic [WIDTH-1:0]       shreg_shifted;

   assign last_bit  = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
   // Ready is forced low during reset so nothing is taken while held.
   assign din_ready = !rst && ((state_q == ST_IDLE) || (last_bit && (GAP == 0)));
   assign xfer      = din_valid && din_ready;

   assign shreg_shifted = (LSB_FIRST != 0) ? {1'b0, shreg_q[WIDTH-1:1]}
                                           : {shreg_q[WIDTH-2:0], 1'b0};

   assign busy      = (state_q != ST_IDLE);
   assign sout_en   = (state_q == ST_SHIFT);
   assign word_done = last_bit;
   assign sout      = sout_en && ((LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1]);

   // State, shift register and counters; reset abandons any word in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   // Next-state: load on transfer, shift per bit, then reload, gap or idle.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               state_d   = ST_SHIFT;
               shreg_d   = din;
               bit_cnt_d = '0;
            end
         end
         ST_SHIFT: begin
            shreg_d   = shreg_shifted;
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (last_bit) begin
               bit_cnt_d = '0;
               if (xfer) begin
                  shreg_d = din;
               end else if (GAP != 0) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
            if (gap_cnt_q == GAP_LAST) begin
               state_d   = ST_IDLE;
               gap_cnt_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
